// File: rtl/fp_result_checker.sv
// Streaming FP result checker: expected-value FIFO, 2-stage ULP compare,
// pass/fail counters with first-mismatch capture.
module fp_result_checker #(
  parameter int WIDTH = 27,
  parameter int EXP_W = 8,
  parameter int DEPTH = 16,
  parameter int TOL   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_data,
  output logic             exp_ready,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_got,
  output logic [WIDTH-1:0] first_fail_exp,
  output logic             underflow_err,
  output logic             leftover_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [WIDTH-2:0] TOL_V = (WIDTH-1)'(TOL);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] fifo_cnt, fifo_cnt_n;
  logic full, empty, push, pop;

  logic [CNT_W-1:0] num_vec_q;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] chk_cnt, chk_n;
  logic start_ok, accept, to_done;

  logic s1_valid, s1_empty;
  logic [WIDTH-1:0] s1_res, s1_exp;
  logic [CNT_W-1:0] s1_idx;
  logic s2_match;

  function automatic logic fp_match(
    input logic [WIDTH-1:0] g,
    input logic [WIDTH-1:0] e
  );
    logic [EXP_W-1:0] ge, ee;
    logic [WIDTH-2:0] gm, em, d;
    ge = g[WIDTH-2 -: EXP_W];
    ee = e[WIDTH-2 -: EXP_W];
    gm = g[WIDTH-2:0];
    em = e[WIDTH-2:0];
    d  = (gm >= em) ? gm - em : em - gm;
    if (ge == '0 && ee == '0)
      return 1'b1;
    else if (&ge || &ee)
      return g == e;
    else
      return (g[WIDTH-1] == e[WIDTH-1]) && (d <= TOL_V);
  endfunction

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign full       = fifo_cnt == FULL_CNT;
  assign empty      = fifo_cnt == '0;
  assign exp_ready  = !full;
  assign push       = exp_valid && !full;
  assign pop        = accept && !empty;
  assign fifo_cnt_n = fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);

  assign start_ok = start && (state != RUN);
  assign accept   = (state == RUN) && res_valid && (acc_cnt < num_vec_q);
  assign chk_n    = s1_valid ? chk_cnt + 1'b1 : chk_cnt;
  assign to_done  = (state == RUN) && (state_n == DONE);
  assign s2_match = !s1_empty && fp_match(s1_res, s1_exp);

  assign busy = state == RUN;
  assign done = state == DONE;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = RUN;
      RUN:  if (chk_n == num_vec_q) state_n = DONE;
      DONE: if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= exp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_vec_q <= '0;
      acc_cnt   <= '0;
    end else if (start_ok) begin
      num_vec_q <= num_vec;
      acc_cnt   <= '0;
    end else if (accept) begin
      acc_cnt   <= acc_cnt + 1'b1;
    end
  end

  // Stage 1: latch result and FIFO head; an empty FIFO supplies exp=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_empty <= 1'b0;
      s1_res   <= '0;
      s1_exp   <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_res   <= res_data;
        s1_exp   <= empty ? '0 : mem[rd_ptr[AW-1:0]];
        s1_idx   <= acc_cnt;
        s1_empty <= empty;
      end
    end
  end

  // Stage 2: compare, count, capture the first mismatch only.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      chk_cnt        <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      underflow_err  <= 1'b0;
      leftover_err   <= 1'b0;
    end else begin
      if (s1_valid) begin
        chk_cnt <= chk_cnt + 1'b1;
        if (s2_match) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          if (s1_empty) underflow_err <= 1'b1;
          if (fail_cnt == '0) begin
            first_fail_idx <= s1_idx;
            first_fail_got <= s1_res;
            first_fail_exp <= s1_exp;
          end
        end
      end
      if (to_done)
        leftover_err <= fifo_cnt_n != '0;
    end
  end

endmodule
